mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter funnelling NUM_PORTS requesters onto a single memory port.
// One transaction in flight at a time; each response is routed back to its granted port, or times out.
module mem_port_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          io_mReq_valid,
  output logic [NUM_PORTS-1:0]          io_mReq_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0]   io_mReq_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   io_mReq_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] io_mReq_be,
  input  logic [NUM_PORTS-1:0]          io_mReq_we,
  output logic [NUM_PORTS-1:0]          io_mRsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   io_mRsp_rdata,
  output logic [NUM_PORTS-1:0]          io_mRsp_err,
  output logic                          io_sReq_valid,
  input  logic                          io_sReq_ready,
  output logic [ADDR_W-1:0]             io_sReq_addr,
  output logic [DATA_W-1:0]             io_sReq_wdata,
  output logic [DATA_W/8-1:0]           io_sReq_be,
  output logic                          io_sReq_we,
  input  logic                          io_sRsp_valid,
  input  logic [DATA_W-1:0]             io_sRsp_rdata
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [PTR_W-1:0]          rr_q, rr_d;
  logic [PTR_W-1:0]          grant_q, grant_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [BE_W-1:0]           be_q, be_d;
  logic                      we_q, we_d;
  logic                      sreq_valid_q, sreq_valid_d;
  logic [NUM_PORTS-1:0]      rsp_valid_q, rsp_valid_d;
  logic [NUM_PORTS*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [NUM_PORTS-1:0]      rsp_err_q, rsp_err_d;

  logic                      arb_found;
  logic [PTR_W-1:0]          arb_idx;
  logic [PTR_W-1:0]          next_rr;
  logic                      timeout_hit;

  // First valid port searching upward from rr_q with wrap
  always_comb begin
    int unsigned idx;
    arb_found = 1'b0;
    arb_idx   = rr_q;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(rr_q) + i) % NUM_PORTS;
      if (!arb_found && io_mReq_valid[PTR_W'(idx)]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'(idx);
      end
    end
  end

  // Accept is combinational and only offered while idle
  always_comb begin
    io_mReq_ready = '0;
    if (state_q == ST_IDLE && arb_found && !reset) begin
      io_mReq_ready[arb_idx] = 1'b1;
    end
  end

  assign next_rr     = (grant_q == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_q + PTR_W'(1);
  // Fires on the last counted cycle so the registered error lands as the counter reaches TIMEOUT
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    sreq_valid_d = sreq_valid_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d      = arb_idx;
          addr_d       = io_mReq_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
          wdata_d      = io_mReq_wdata[32'(arb_idx)*DATA_W +: DATA_W];
          be_d         = io_mReq_be[32'(arb_idx)*BE_W +: BE_W];
          we_d         = io_mReq_we[arb_idx];
          sreq_valid_d = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (io_sReq_ready) begin
          sreq_valid_d = 1'b0;
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (io_sRsp_valid) begin
          rsp_valid_d[grant_q]                         = 1'b1;
          rsp_rdata_d[32'(grant_q)*DATA_W +: DATA_W]   = io_sRsp_rdata;
          rr_d                                         = next_rr;
          state_d                                      = ST_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d[grant_q]   = 1'b1;
          rr_d                 = next_rr;
          state_d              = ST_IDLE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        sreq_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      sreq_valid_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      sreq_valid_q <= sreq_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign io_sReq_valid = sreq_valid_q;
  assign io_sReq_addr  = addr_q;
  assign io_sReq_wdata = wdata_q;
  assign io_sReq_be    = be_q;
  assign io_sReq_we    = we_q;
  assign io_mRsp_valid = rsp_valid_q;
  assign io_mRsp_rdata = rsp_rdata_q;
  assign io_mRsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: 4 ports, TIMEOUT=4, hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 4;

  logic clock = 1'b0;
  logic reset;
  logic [NP-1:0]    m_valid, m_ready, m_we, r_valid, r_err;
  logic [NP*AW-1:0] m_addr;
  logic [NP*DW-1:0] m_wdata, r_rdata;
  logic [NP*BW-1:0] m_be;
  logic             s_valid, s_ready, s_we, sr_valid;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata, sr_rdata;
  logic [BW-1:0]    s_be;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .io_mReq_valid(m_valid), .io_mReq_ready(m_ready), .io_mReq_addr(m_addr),
    .io_mReq_wdata(m_wdata), .io_mReq_be(m_be), .io_mReq_we(m_we),
    .io_mRsp_valid(r_valid), .io_mRsp_rdata(r_rdata), .io_mRsp_err(r_err),
    .io_sReq_valid(s_valid), .io_sReq_ready(s_ready), .io_sReq_addr(s_addr),
    .io_sReq_wdata(s_wdata), .io_sReq_be(s_be), .io_sReq_we(s_we),
    .io_sRsp_valid(sr_valid), .io_sRsp_rdata(sr_rdata)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full transaction for port p; rsp_at < 0 means memory never answers
  task automatic run_txn(input int p, input bit keep, input int stall, input int rsp_at,
                         input logic [DW-1:0] rdata);
    logic [AW-1:0]    ea;
    logic [DW-1:0]    ew;
    logic [BW-1:0]    eb;
    logic             ewe;
    logic [NP-1:0]    oh;
    logic [NP*DW-1:0] erd;
    oh  = NP'(1) << p;
    erd = '0;
    #1;
    check("accept_ready", 128'(m_ready), 128'(oh));
    ea  = m_addr[p*AW +: AW];
    ew  = m_wdata[p*DW +: DW];
    eb  = m_be[p*BW +: BW];
    ewe = m_we[p];
    step();
    if (!keep) m_valid[p] = 1'b0;
    m_addr[p*AW +: AW]  = ea + 32'h4;
    m_wdata[p*DW +: DW] = ~ew;
    #1;
    check("req_valid", 128'(s_valid), 128'(1'b1));
    check("req_ready_low", 128'(m_ready), 128'(0));
    check("rsp_pulse_done", 128'(r_valid), 128'(0));
    check("req_addr", 128'(s_addr), 128'(ea));
    check("req_wdata", 128'(s_wdata), 128'(ew));
    check("req_be", 128'(s_be), 128'(eb));
    check("req_we", 128'(s_we), 128'(ewe));
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", 128'(s_valid), 128'(1'b1));
      check("stall_addr", 128'(s_addr), 128'(ea));
      check("stall_wdata", 128'(s_wdata), 128'(ew));
      check("stall_be", 128'(s_be), 128'(eb));
    end
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    check("wait_sreq_low", 128'(s_valid), 128'(0));
    check("wait_ready_low", 128'(m_ready), 128'(0));
    if (rsp_at >= 0) begin
      for (int i = 0; i < rsp_at; i++) begin
        step();
        check("wait_no_rsp", 128'(r_valid), 128'(0));
      end
      sr_valid = 1'b1;
      sr_rdata = rdata;
      step();
      sr_valid = 1'b0;
      sr_rdata = '0;
      erd[p*DW +: DW] = rdata;
      check("rsp_valid", 128'(r_valid), 128'(oh));
      check("rsp_rdata", 128'(r_rdata), 128'(erd));
      check("rsp_err", 128'(r_err), 128'(0));
    end else begin
      for (int i = 1; i <= int'(TO); i++) begin
        step();
        if (i < int'(TO)) check("to_no_rsp", 128'(r_valid), 128'(0));
      end
      check("to_valid", 128'(r_valid), 128'(oh));
      check("to_err", 128'(r_err), 128'(oh));
      check("to_rdata", 128'(r_rdata), 128'(0));
    end
  endtask

  initial begin
    reset    = 1'b1;
    m_valid  = 4'b1111;
    m_we     = '0;
    m_addr   = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0010};
    m_wdata  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    m_be     = 16'hFFFF;
    s_ready  = 1'b0;
    sr_valid = 1'b0;
    sr_rdata = '0;
    step();
    step();
    check("rst_ready", 128'(m_ready), 128'(0));
    check("rst_sreq_valid", 128'(s_valid), 128'(0));
    check("rst_rsp_valid", 128'(r_valid), 128'(0));
    check("rst_rsp_rdata", 128'(r_rdata), 128'(0));
    check("rst_rsp_err", 128'(r_err), 128'(0));
    check("rst_sreq_addr", 128'(s_addr), 128'(0));
    m_valid = '0;
    reset   = 1'b0;
    step();

    // Single zero-wait read on port 0
    m_valid = 4'b0001;
    run_txn(0, 1'b0, 0, 0, 32'hDEAD_BEEF);

    // Write from port 2 held through a 5-cycle stall
    m_valid               = 4'b0100;
    m_we[2]               = 1'b1;
    m_be[2*BW +: BW]      = 4'b0011;
    m_wdata[2*DW +: DW]   = 32'hAABB_CCDD;
    run_txn(2, 1'b0, 5, 1, 32'h0000_1234);
    m_we = '0;

    // Timeout on port 3 (search wraps from 3), port 1 waiting behind it
    m_valid = 4'b1010;
    run_txn(3, 1'b0, 0, -1, '0);
    // Response coinciding with the timeout cycle wins
    run_txn(1, 1'b0, 0, 3, 32'hCAFE_F00D);

    // Stray memory response while idle
    sr_valid = 1'b1;
    sr_rdata = 32'h1234_5678;
    step();
    sr_valid = 1'b0;
    sr_rdata = '0;
    check("stray_rsp_valid", 128'(r_valid), 128'(0));
    check("stray_rsp_rdata", 128'(r_rdata), 128'(0));
    check("stray_sreq", 128'(s_valid), 128'(0));

    // Reset while waiting on memory drops the transaction
    m_valid = 4'b0100;
    #1;
    check("mid_accept", 128'(m_ready), 128'(4'b0100));
    step();
    m_valid = '0;
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_sreq", 128'(s_valid), 128'(0));
    check("mid_rst_addr", 128'(s_addr), 128'(0));
    check("mid_rst_rsp", 128'(r_valid), 128'(0));
    sr_valid = 1'b1;
    sr_rdata = 32'h5555_AAAA;
    step();
    sr_valid = 1'b0;
    sr_rdata = '0;
    reset    = 1'b0;
    step();
    check("post_rst_rsp", 128'(r_valid), 128'(0));
    check("post_rst_err", 128'(r_err), 128'(0));
    m_valid = 4'b0011;
    #1;
    check("post_rst_first", 128'(m_ready), 128'(4'b0001));

    // Full contention from a fresh pointer: 0,1,2,3,0
    m_valid = 4'b1111;
    run_txn(0, 1'b1, 0, 0, 32'h1000_0000);
    run_txn(1, 1'b1, 0, 0, 32'h1000_0001);
    run_txn(2, 1'b1, 0, 0, 32'h1000_0002);
    run_txn(3, 1'b1, 0, 0, 32'h1000_0003);
    run_txn(0, 1'b1, 0, 0, 32'h1000_0004);
    m_valid = '0;
    step();
    check("final_pulse_done", 128'(r_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
